// File: rtl/clk_mgr_pkg.sv
// Shared definitions for the PLL lock/reset supervisor.
//   state_e     : supervisor FSM state encoding (also the value of the state readback)
//   timer_width : width of the shared state timer for a given set of cycle counts
//   sat_inc     : saturating increment for the event counters
package clk_mgr_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_e;

  // $clog2 of the largest cycle count plus one spare bit, so that every
  // terminal count fits comfortably.
  function automatic int unsigned timer_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c,
                                              input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0]   v,
                                          input int unsigned   w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/clk_mgr_supervisor_if.sv
// Slow-control bus of the clock supervisor.
//   sw_reset      : one-cycle request to restart the PLL sequence
//   clear_counts  : one-cycle clear of both event counters
//   state         : encoded supervisor state (clk_mgr_pkg::state_e values)
//   lock_loss_cnt : saturating count of lock losses after stabilisation
//   retry_cnt     : saturating count of lock-wait timeouts
// master = slow-control host, slave = supervisor.
interface clk_mgr_supervisor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             sw_reset;
  logic             clear_counts;
  logic [2:0]       state;
  logic [CNT_W-1:0] lock_loss_cnt;
  logic [CNT_W-1:0] retry_cnt;

  modport master (
    output sw_reset, clear_counts,
    input  state, lock_loss_cnt, retry_cnt
  );

  modport slave (
    input  sw_reset, clear_counts,
    output state, lock_loss_cnt, retry_cnt
  );
endinterface

// File: rtl/clk_mgr_supervisor_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears every stage to 0
//   d_i    : asynchronous input
//   q_o    : synchronised output, STAGES cycles of latency
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_mgr_supervisor.sv
// Lock/reset supervisor for a multi-output PLL, clocked by the PLL refclk.
// Pulses the PLL reset, waits for a synchronised and debounced lock, then
// releases one active-low domain reset per PLL output in ascending index
// order. Lock loss or a software request restarts the sequence.
//   refclk     : sole clock (PLL reference clock)
//   rst_n      : asynchronous active-low reset
//   pll_locked : asynchronous PLL lock indication
//   pll_rst    : PLL reset, active-high
//   clk_rst_n  : per-domain resets, active-low, bit i for PLL outclk_i
//   all_ready  : high only in RUN
//   ctl        : slow-control bus (sw_reset, clear_counts, state, counters)
module clk_mgr_supervisor
  import clk_mgr_pkg::*;
#(
  parameter int unsigned          N_CLOCKS           = 5,
  parameter int unsigned          RST_PULSE_CYCLES   = 16,
  parameter int unsigned          LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned          RELOCK_TIMEOUT     = 65536,
  parameter int unsigned          STAGGER_CYCLES     = 8,
  parameter logic [N_CLOCKS-1:0]  CLK_EN_MASK        = '1,
  parameter int unsigned          CNT_W              = 8
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic [N_CLOCKS-1:0] clk_rst_n,
  output logic                all_ready,
  clk_mgr_supervisor_if.slave ctl
);

  localparam int unsigned TW = timer_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                           RELOCK_TIMEOUT, N_CLOCKS * STAGGER_CYCLES);

  localparam logic [TW-1:0] T_PULSE_END   = TW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] T_STABLE_END  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] T_TIMEOUT_END = TW'(RELOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_RELEASE_END = TW'((N_CLOCKS - 1) * STAGGER_CYCLES);

  logic lk_s;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             lock_loss_ev, retry_ev;

  logic                pll_rst_q, pll_rst_d;
  logic [N_CLOCKS-1:0] clk_rst_n_q, clk_rst_n_d;
  logic                all_ready_q, all_ready_d;
  logic [CNT_W-1:0]    lock_loss_q, lock_loss_d;
  logic [CNT_W-1:0]    retry_q, retry_d;

  sync_bit #(
    .STAGES (2)
  ) u_lock_sync (
    .clk_i  (refclk),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lk_s)
  );

  // State register and shared timer.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next state. sw_reset overrides the transition but not the event flags,
  // so a lock loss in the same cycle is still counted.
  always_comb begin
    state_d      = state_q;
    lock_loss_ev = 1'b0;
    retry_ev     = 1'b0;
    case (state_q)
      PLL_RST: begin
        if (timer_q == T_PULSE_END) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lk_s) begin
          state_d = STABLE;
        end else if (timer_q == T_TIMEOUT_END) begin
          state_d  = PLL_RST;
          retry_ev = 1'b1;
        end
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
        end else if (timer_q == T_STABLE_END) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!lk_s) begin
          state_d      = PLL_RST;
          lock_loss_ev = 1'b1;
        end else if (timer_q == T_RELEASE_END) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d      = PLL_RST;
          lock_loss_ev = 1'b1;
        end
      end
      default: state_d = PLL_RST;
    endcase
    if (ctl.sw_reset) state_d = PLL_RST;
    // sw_reset in PLL_RST is not a state change but must still restart the pulse.
    timer_d = (ctl.sw_reset || (state_d != state_q)) ? '0 : timer_q + TW'(1);
  end

  // Outputs are decoded from the next state so the registered outputs
  // change on the same edge as the state itself.
  always_comb begin
    pll_rst_d   = (state_d == PLL_RST);
    all_ready_d = (state_d == RUN);
    clk_rst_n_d = '0;
    case (state_d)
      RELEASE: begin
        clk_rst_n_d = clk_rst_n_q;
        for (int unsigned k = 0; k < N_CLOCKS; k++) begin
          if (timer_d == TW'(k * STAGGER_CYCLES)) clk_rst_n_d[k] = CLK_EN_MASK[k];
        end
      end
      RUN:     clk_rst_n_d = CLK_EN_MASK;
      default: clk_rst_n_d = '0;
    endcase
  end

  always_comb begin
    lock_loss_d = lock_loss_q;
    retry_d     = retry_q;
    if (lock_loss_ev) lock_loss_d = CNT_W'(sat_inc(32'(lock_loss_q), CNT_W));
    if (retry_ev)     retry_d     = CNT_W'(sat_inc(32'(retry_q), CNT_W));
    if (ctl.clear_counts) begin
      lock_loss_d = '0;
      retry_d     = '0;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      clk_rst_n_q <= '0;
      all_ready_q <= 1'b0;
      lock_loss_q <= '0;
      retry_q     <= '0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      clk_rst_n_q <= clk_rst_n_d;
      all_ready_q <= all_ready_d;
      lock_loss_q <= lock_loss_d;
      retry_q     <= retry_d;
    end
  end

  assign pll_rst           = pll_rst_q;
  assign clk_rst_n         = clk_rst_n_q;
  assign all_ready         = all_ready_q;
  assign ctl.state         = state_q;
  assign ctl.lock_loss_cnt = lock_loss_q;
  assign ctl.retry_cnt     = retry_q;

endmodule

// File: tb/tb_clk_mgr_supervisor.sv
// Directed bench for clk_mgr_supervisor. dut_a (CNT_W=8) has lock present
// from time 0; dut_b (CNT_W=2) never sees lock and exercises the retry path.
module tb_clk_mgr_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n_a, rst_n_b;
  logic       lock_a, lock_b;
  logic       pll_rst_a, pll_rst_b;
  logic [4:0] crn_a, crn_b;
  logic       rdy_a, rdy_b;

  int checks   = 0;
  int failures = 0;

  clk_mgr_supervisor_if #(.CNT_W(8)) ctl_a ();
  clk_mgr_supervisor_if #(.CNT_W(2)) ctl_b ();

  clk_mgr_supervisor #(
    .N_CLOCKS           (5),
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .RELOCK_TIMEOUT     (32),
    .STAGGER_CYCLES     (2),
    .CLK_EN_MASK        (5'b11011),
    .CNT_W              (8)
  ) dut_a (
    .refclk     (refclk),
    .rst_n      (rst_n_a),
    .pll_locked (lock_a),
    .pll_rst    (pll_rst_a),
    .clk_rst_n  (crn_a),
    .all_ready  (rdy_a),
    .ctl        (ctl_a)
  );

  clk_mgr_supervisor #(
    .N_CLOCKS           (5),
    .RST_PULSE_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .RELOCK_TIMEOUT     (32),
    .STAGGER_CYCLES     (2),
    .CLK_EN_MASK        (5'b11011),
    .CNT_W              (2)
  ) dut_b (
    .refclk     (refclk),
    .rst_n      (rst_n_b),
    .pll_locked (lock_b),
    .pll_rst    (pll_rst_b),
    .clk_rst_n  (crn_b),
    .all_ready  (rdy_b),
    .ctl        (ctl_b)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  task automatic wait_state_a(input logic [2:0] st, input int budget);
    int n;
    n = 0;
    while (ctl_a.state !== st && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (ctl_a.state !== st) begin
      failures++;
      $display("FAIL wait_state_a got=%0d exp=%0d after %0d cycles", ctl_a.state, st, n);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (pll_rst_a !== 1'b1 || crn_a !== 5'b00000 || rdy_a !== 1'b0 || ctl_a.state !== 3'd0 ||
        ctl_a.lock_loss_cnt !== 8'd0 || ctl_a.retry_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_a got pll_rst=%b crn=%b rdy=%b st=%0d ll=%0d rt=%0d exp 1 00000 0 0 0 0",
               pll_rst_a, crn_a, rdy_a, ctl_a.state, ctl_a.lock_loss_cnt, ctl_a.retry_cnt);
    end
    checks++;
    if (pll_rst_b !== 1'b1 || crn_b !== 5'b00000 || rdy_b !== 1'b0 || ctl_b.state !== 3'd0 ||
        ctl_b.retry_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_b got pll_rst=%b crn=%b rdy=%b st=%0d rt=%0d exp 1 00000 0 0 0",
               pll_rst_b, crn_b, rdy_b, ctl_b.state, ctl_b.retry_cnt);
    end
  endtask

  task automatic test_power_up();
    logic [4:0] exp_rel [10];
    logic [2:0] exp_st;
    exp_rel = '{5'b00001, 5'b00001, 5'b00011, 5'b00011, 5'b00011,
                5'b00011, 5'b01011, 5'b01011, 5'b11011, 5'b11011};
    rst_n_a = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (pll_rst_a !== 1'b1 || ctl_a.state !== 3'd0) begin
        failures++;
        $display("FAIL pulse edge=%0d got pll_rst=%b st=%0d exp 1 0", i, pll_rst_a, ctl_a.state);
      end
    end
    tick();
    checks++;
    if (pll_rst_a !== 1'b0 || ctl_a.state !== 3'd1) begin
      failures++;
      $display("FAIL pulse_end got pll_rst=%b st=%0d exp 0 1", pll_rst_a, ctl_a.state);
    end
    tick();
    checks++;
    if (ctl_a.state !== 3'd2) begin
      failures++;
      $display("FAIL stable_entry got st=%0d exp 2", ctl_a.state);
    end
    repeat (7) tick();
    checks++;
    if (ctl_a.state !== 3'd2 || crn_a !== 5'b00000) begin
      failures++;
      $display("FAIL stable_last got st=%0d crn=%b exp 2 00000", ctl_a.state, crn_a);
    end
    tick();
    for (int off = 0; off < 10; off++) begin
      if (off > 0) tick();
      exp_st = (off == 9) ? 3'd4 : 3'd3;
      checks++;
      if (crn_a !== exp_rel[off] || rdy_a !== (off == 9) || ctl_a.state !== exp_st) begin
        failures++;
        $display("FAIL release off=%0d got crn=%b rdy=%b st=%0d exp crn=%b rdy=%b st=%0d",
                 off, crn_a, rdy_a, ctl_a.state, exp_rel[off], (off == 9), exp_st);
      end
    end
  endtask

  task automatic test_stable_glitch();
    ctl_a.sw_reset = 1'b1;
    tick();
    ctl_a.sw_reset = 1'b0;
    checks++;
    if (ctl_a.state !== 3'd0 || crn_a !== 5'b00000 || rdy_a !== 1'b0 || pll_rst_a !== 1'b1 ||
        ctl_a.lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL sw_reset got st=%0d crn=%b rdy=%b pll_rst=%b ll=%0d exp 0 00000 0 1 0",
               ctl_a.state, crn_a, rdy_a, pll_rst_a, ctl_a.lock_loss_cnt);
    end
    repeat (5) tick();
    checks++;
    if (ctl_a.state !== 3'd2) begin
      failures++;
      $display("FAIL glitch_pre got st=%0d exp 2", ctl_a.state);
    end
    repeat (3) tick();
    lock_a = 1'b0;
    tick();
    lock_a = 1'b1;
    tick();
    checks++;
    if (ctl_a.state !== 3'd2) begin
      failures++;
      $display("FAIL glitch_hold got st=%0d exp 2", ctl_a.state);
    end
    tick();
    checks++;
    if (ctl_a.state !== 3'd1 || ctl_a.lock_loss_cnt !== 8'd0) begin
      failures++;
      $display("FAIL glitch_drop got st=%0d ll=%0d exp 1 0", ctl_a.state, ctl_a.lock_loss_cnt);
    end
    tick();
    repeat (7) tick();
    checks++;
    if (ctl_a.state !== 3'd2) begin
      failures++;
      $display("FAIL restable got st=%0d exp 2", ctl_a.state);
    end
    tick();
    checks++;
    if (ctl_a.state !== 3'd3 || crn_a !== 5'b00001) begin
      failures++;
      $display("FAIL restable_rel got st=%0d crn=%b exp 3 00001", ctl_a.state, crn_a);
    end
    repeat (9) tick();
    checks++;
    if (ctl_a.state !== 3'd4 || rdy_a !== 1'b1) begin
      failures++;
      $display("FAIL rerun got st=%0d rdy=%b exp 4 1", ctl_a.state, rdy_a);
    end
  endtask

  task automatic test_run_loss();
    lock_a = 1'b0;
    tick();
    tick();
    checks++;
    if (rdy_a !== 1'b1 || crn_a !== 5'b11011) begin
      failures++;
      $display("FAIL loss_latency got rdy=%b crn=%b exp 1 11011", rdy_a, crn_a);
    end
    tick();
    checks++;
    if (rdy_a !== 1'b0 || crn_a !== 5'b00000 || ctl_a.state !== 3'd0 || pll_rst_a !== 1'b1 ||
        ctl_a.lock_loss_cnt !== 8'd1) begin
      failures++;
      $display("FAIL run_loss got rdy=%b crn=%b st=%0d pll_rst=%b ll=%0d exp 0 00000 0 1 1",
               rdy_a, crn_a, ctl_a.state, pll_rst_a, ctl_a.lock_loss_cnt);
    end
    lock_a = 1'b1;
  endtask

  task automatic test_counter_accumulate();
    for (int i = 0; i < 6; i++) begin
      wait_state_a(3'd4, 100);
      lock_a = 1'b0;
      repeat (3) tick();
      lock_a = 1'b1;
    end
    checks++;
    if (ctl_a.lock_loss_cnt !== 8'd7 || ctl_a.retry_cnt !== 8'd0) begin
      failures++;
      $display("FAIL accumulate got ll=%0d rt=%0d exp 7 0", ctl_a.lock_loss_cnt, ctl_a.retry_cnt);
    end
  endtask

  task automatic test_clear_priority();
    wait_state_a(3'd4, 100);
    lock_a = 1'b0;
    tick();
    tick();
    ctl_a.sw_reset     = 1'b1;
    ctl_a.clear_counts = 1'b1;
    tick();
    ctl_a.sw_reset     = 1'b0;
    ctl_a.clear_counts = 1'b0;
    checks++;
    if (ctl_a.state !== 3'd0 || ctl_a.lock_loss_cnt !== 8'd0 || crn_a !== 5'b00000 || rdy_a !== 1'b0) begin
      failures++;
      $display("FAIL clear_wins got st=%0d ll=%0d crn=%b rdy=%b exp 0 0 00000 0",
               ctl_a.state, ctl_a.lock_loss_cnt, crn_a, rdy_a);
    end
    lock_a = 1'b1;
  endtask

  task automatic test_async_reset();
    wait_state_a(3'd3, 100);
    tick();
    tick();
    checks++;
    if (crn_a !== 5'b00011) begin
      failures++;
      $display("FAIL mid_release got crn=%b exp 00011", crn_a);
    end
    #2;
    rst_n_a = 1'b0;
    #1;
    checks++;
    if (pll_rst_a !== 1'b1 || crn_a !== 5'b00000 || rdy_a !== 1'b0 || ctl_a.state !== 3'd0) begin
      failures++;
      $display("FAIL async_reset got pll_rst=%b crn=%b rdy=%b st=%0d exp 1 00000 0 0",
               pll_rst_a, crn_a, rdy_a, ctl_a.state);
    end
    repeat (10) tick();
    checks++;
    if (crn_a !== 5'b00000 || ctl_a.state !== 3'd0) begin
      failures++;
      $display("FAIL reset_hold got crn=%b st=%0d exp 00000 0", crn_a, ctl_a.state);
    end
    rst_n_a = 1'b1;
  endtask

  task automatic test_retry();
    rst_n_b = 1'b1;
    for (int i = 1; i <= 144; i++) begin
      tick();
      case (i)
        35: begin
          checks++;
          if (ctl_b.state !== 3'd1 || ctl_b.retry_cnt !== 2'd0) begin
            failures++;
            $display("FAIL retry_pre got st=%0d rt=%0d exp 1 0", ctl_b.state, ctl_b.retry_cnt);
          end
        end
        36: begin
          checks++;
          if (ctl_b.state !== 3'd0 || pll_rst_b !== 1'b1 || ctl_b.retry_cnt !== 2'd1) begin
            failures++;
            $display("FAIL retry1 got st=%0d pll_rst=%b rt=%0d exp 0 1 1",
                     ctl_b.state, pll_rst_b, ctl_b.retry_cnt);
          end
        end
        39: begin
          checks++;
          if (ctl_b.state !== 3'd0) begin
            failures++;
            $display("FAIL retry_pulse got st=%0d exp 0", ctl_b.state);
          end
        end
        40: begin
          checks++;
          if (ctl_b.state !== 3'd1 || pll_rst_b !== 1'b0) begin
            failures++;
            $display("FAIL retry_wait got st=%0d pll_rst=%b exp 1 0", ctl_b.state, pll_rst_b);
          end
        end
        72: begin
          checks++;
          if (ctl_b.state !== 3'd0 || ctl_b.retry_cnt !== 2'd2) begin
            failures++;
            $display("FAIL retry2 got st=%0d rt=%0d exp 0 2", ctl_b.state, ctl_b.retry_cnt);
          end
        end
        108: begin
          checks++;
          if (ctl_b.state !== 3'd0 || ctl_b.retry_cnt !== 2'd3) begin
            failures++;
            $display("FAIL retry3 got st=%0d rt=%0d exp 0 3", ctl_b.state, ctl_b.retry_cnt);
          end
        end
        144: begin
          checks++;
          if (ctl_b.state !== 3'd0 || ctl_b.retry_cnt !== 2'd3 || crn_b !== 5'b00000 || rdy_b !== 1'b0) begin
            failures++;
            $display("FAIL retry_sat got st=%0d rt=%0d crn=%b rdy=%b exp 0 3 00000 0",
                     ctl_b.state, ctl_b.retry_cnt, crn_b, rdy_b);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_sw_reset_restart();
    tick();
    ctl_b.sw_reset = 1'b1;
    tick();
    ctl_b.sw_reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (ctl_b.state !== 3'd0 || pll_rst_b !== 1'b1) begin
      failures++;
      $display("FAIL pulse_restart got st=%0d pll_rst=%b exp 0 1", ctl_b.state, pll_rst_b);
    end
    tick();
    checks++;
    if (ctl_b.state !== 3'd1) begin
      failures++;
      $display("FAIL pulse_restart_end got st=%0d exp 1", ctl_b.state);
    end
  endtask

  initial begin
    rst_n_a            = 1'b0;
    rst_n_b            = 1'b0;
    lock_a             = 1'b1;
    lock_b             = 1'b0;
    ctl_a.sw_reset     = 1'b0;
    ctl_a.clear_counts = 1'b0;
    ctl_b.sw_reset     = 1'b0;
    ctl_b.clear_counts = 1'b0;

    test_reset();
    test_power_up();
    test_stable_glitch();
    test_run_loss();
    test_counter_accumulate();
    test_clear_priority();
    test_async_reset();
    test_retry();
    test_sw_reset_restart();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
